// File: rtl/mos6502s_pkg.sv
// Shared types and constants for the 6502 bus responder: FSM states, address
// regions, region base addresses and the value returned by an aborted read.
package mos6502s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_IO,
    RGN_ROM
  } region_t;

  localparam logic [15:0] IO_BASE       = 16'h8000;
  localparam logic [15:0] ROM_BASE      = 16'hC000;
  localparam logic [7:0]  TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/mos6502s_region_decode.sv
// Combinational address-to-region decode: RAM below IO_BASE, I/O below ROM_BASE,
// ROM above.
module mos6502s_region_decode
  import mos6502s_pkg::*;
(
  input  logic [15:0] addr,
  output region_t     region
);

  always_comb begin
    region = RGN_RAM;
    if (addr >= ROM_BASE)     region = RGN_ROM;
    else if (addr >= IO_BASE) region = RGN_IO;
  end

endmodule

// File: rtl/mos6502s_bus_responder.sv
// Memory-side responder for the 6502 core: region decode, backing-memory
// handshake, I/O wait states and RDY stall. Define MOS6502S_RESP_TIMEOUT_EN to
// abort requests that go unacknowledged for TIMEOUT cycles.
module mos6502s_bus_responder
  import mos6502s_pkg::*;
#(
  parameter int IO_WAIT = 2,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  if (IO_WAIT < 0 || IO_WAIT > 15) begin : g_bad_io_wait
    $error("IO_WAIT out of range 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT out of range 1..255");
  end

  state_t     state;
  region_t    addr_rgn;
  region_t    rgn_q;
  logic       rw_q;
  logic [3:0] wait_cnt;

  mos6502s_region_decode u_dec (
    .addr   (cpu_addr),
    .region (addr_rgn)
  );

  assign cpu_rdy = (state == ST_IDLE) || (state == ST_DONE);

`ifdef MOS6502S_RESP_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rgn_q     <= RGN_RAM;
      rw_q      <= 1'b1;
      wait_cnt  <= '0;
      cpu_din   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MOS6502S_RESP_TIMEOUT_EN
      to_cnt    <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (cpu_valid) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_dout;
            rw_q      <= cpu_rw;
            rgn_q     <= addr_rgn;
            // ROM writes are swallowed without touching the memory port
            if (addr_rgn == RGN_ROM && !cpu_rw) begin
              state <= ST_DONE;
            end else begin
              state   <= ST_REQ;
              mem_req <= 1'b1;
              mem_we  <= !cpu_rw;
`ifdef MOS6502S_RESP_TIMEOUT_EN
              to_cnt  <= '0;
`endif
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (rw_q) cpu_din <= mem_rdata;
            if (rgn_q == RGN_IO && IO_WAIT > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(IO_WAIT);
            end else begin
              state <= ST_DONE;
            end
          end
`ifdef MOS6502S_RESP_TIMEOUT_EN
          // an ack landing on the expiry cycle takes the branch above
          else if (to_cnt == TO_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (rw_q) cpu_din <= TIMEOUT_RDATA;
            bus_err <= 1'b1;
            state   <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        ST_WAIT: begin
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= '0;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mos6502s_bus_responder.sv
// Directed bench for mos6502s_bus_responder with a read-data scoreboard.
module tb_mos6502s_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        cpu_valid;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_din;

  mos6502s_bus_responder #(.IO_WAIT(2), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_valid (cpu_valid),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_din   (cpu_din),
    .cpu_rdy   (cpu_rdy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access, driven at a negedge. Returns at the negedge of the DONE cycle.
  task automatic access(input string tag, input logic rw, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] rd, input logic ack,
                        input logic exp_req, input int exp_low);
    int low;
    logic [7:0] exp_din;
    cpu_valid = 1'b1;
    cpu_rw    = rw;
    cpu_addr  = a;
    cpu_dout  = wd;
    if (rw) last_din = ack ? rd : 8'hFF;
    exp_q.push_back(last_din);
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
    chk({tag, " mem_req"}, 16'(mem_req), 16'(exp_req));
    if (exp_req) begin
      chk({tag, " mem_addr"}, mem_addr, a);
      chk({tag, " mem_we"}, 16'(mem_we), 16'(!rw));
      if (!rw) chk({tag, " mem_wdata"}, 16'(mem_wdata), 16'(wd));
      if (ack) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
    end
    low = 0;
    while (!cpu_rdy && low < 20) begin
      low++;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      mem_rdata = 8'h00;
      @(negedge clk);
    end
    chk({tag, " rdy_low_cycles"}, 16'(low), 16'(exp_low));
    chk({tag, " req_done"}, 16'(mem_req), 16'h0);
    exp_din = exp_q.pop_front();
    chk({tag, " cpu_din"}, 16'(cpu_din), 16'(exp_din));
  endtask

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_valid = 1'b0;
    cpu_rw    = 1'b1;
    cpu_addr  = '0;
    cpu_dout  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    last_din  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst cpu_rdy", 16'(cpu_rdy), 16'h1);
    chk("rst mem_req", 16'(mem_req), 16'h0);
    chk("rst mem_we", 16'(mem_we), 16'h0);
    chk("rst mem_addr", mem_addr, 16'h0000);
    chk("rst mem_wdata", 16'(mem_wdata), 16'h0);
    chk("rst cpu_din", 16'(cpu_din), 16'h0);
    chk("rst bus_err", 16'(bus_err), 16'h0);
    rst_n = 1'b1;
    idle();

    access("ram_rd", 1'b1, 16'h1234, 8'h00, 8'h5A, 1'b1, 1'b1, 1);
    idle();
    access("io_wr", 1'b0, 16'h8010, 8'hA5, 8'h00, 1'b1, 1'b1, 3);
    idle();
    access("rom_wr", 1'b0, 16'hF000, 8'h3C, 8'h00, 1'b1, 1'b0, 0);
    idle();
    // second access issued from DONE: its request must appear with no IDLE gap
    access("b2b_rd1", 1'b1, 16'h0001, 8'h00, 8'h11, 1'b1, 1'b1, 1);
    access("b2b_rd2", 1'b1, 16'h0002, 8'h00, 8'h22, 1'b1, 1'b1, 1);
    idle();
    access("io_rd", 1'b1, 16'hBFFF, 8'h00, 8'h3C, 1'b1, 1'b1, 3);
    idle();
    access("ram_top_rd", 1'b1, 16'h7FFF, 8'h00, 8'h81, 1'b1, 1'b1, 1);
    idle();
    access("rom_rd", 1'b1, 16'hC000, 8'h00, 8'h77, 1'b1, 1'b1, 1);
    idle();
    chk("bus_err clean", 16'(bus_err), 16'h0);

`ifdef MOS6502S_RESP_TIMEOUT_EN
    access("to_rd", 1'b1, 16'h0100, 8'h00, 8'h00, 1'b0, 1'b1, 4);
    chk("to bus_err", 16'(bus_err), 16'h1);
    idle();
    access("after_to_rd", 1'b1, 16'h0200, 8'h00, 8'h44, 1'b1, 1'b1, 1);
    chk("sticky bus_err", 16'(bus_err), 16'h1);
    idle();
`endif

    // reset in the middle of a request
    cpu_valid = 1'b1;
    cpu_rw    = 1'b1;
    cpu_addr  = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
    chk("mid_rst req_up", 16'(mem_req), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst mem_req", 16'(mem_req), 16'h0);
    chk("mid_rst cpu_rdy", 16'(cpu_rdy), 16'h1);
    chk("mid_rst cpu_din", 16'(cpu_din), 16'h0);
    last_din = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst bus_err", 16'(bus_err), 16'h0);
    idle();
    access("post_rst_rd", 1'b1, 16'h4321, 8'h00, 8'h99, 1'b1, 1'b1, 1);
    idle();
    chk("scoreboard empty", 16'(exp_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mos6502s_bus_responder.md
# mos6502s_bus_responder

Memory-side responder for the MOS 6502 synthesizable core. It receives the CPU's latched 16-bit address, read/write strobe and write data, and decodes the address into RAM, I/O or ROM regions. It runs a handshake with a variable-latency backing memory port, inserts I/O wait states, and returns read data to the CPU with a RDY stall. It sits between the CPU address/data path and the system memory/peripheral fabric.

## Interface
Parameters:
- IO_WAIT, default 2: extra stall cycles after `mem_ack` for I/O-region accesses (0–15).
- TIMEOUT, default 15: cycles in REQ without `mem_ack` before the access is aborted (1–255; used only with the timeout feature).

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  **reset is asynchronous and active-low**.
- `cpu_valid`  in  1  CPU presents a bus cycle this clock.
- `cpu_rw`  in  1  1 = read, 0 = write.
- `cpu_addr`  in  16  CPU address.
- `cpu_dout`  in  8  CPU write data.
- `cpu_din`  out  8  read data returned to the CPU.
- `cpu_rdy`  out  1  1 = the responder can accept a cycle or a cycle has just completed.
- `mem_req`  out  1  backing-memory request, held until acknowledged.
- `mem_we`  out  1  write enable for the request.
- `mem_addr`  out  16  latched request address.
- `mem_wdata`  out  8  latched write data.
- `mem_rdata`  in  8  backing-memory read data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle acknowledge.
- `bus_err`  out  1  sticky error flag for timeout aborts.

## Operation
Region decode, taken from the latched address:
- RAM: $0000–$7FFF.
- I/O: $8000–$BFFF.
- ROM: $C000–$FFFF.

States:
- **IDLE**: `cpu_rdy`=1. On a sampled `cpu_valid`:
  - latch `cpu_addr`, `cpu_dout`, `cpu_rw` and region;
  - ROM write → DONE (dropped: no `mem_req`, `cpu_din` unchanged);
  - otherwise → REQ.
- **REQ**: `mem_req`=1, and `mem_we`=!rw. On `mem_ack`:
  - read: capture `mem_rdata` into `cpu_din`;
  - I/O region with IO_WAIT>0 → WAIT (counter loaded with IO_WAIT);
  - otherwise → DONE.
- **WAIT**: counter decrements each cycle. At 1 → DONE.
- **DONE**: `cpu_rdy`=1 for this cycle. A sampled `cpu_valid` is accepted exactly as in IDLE (back-to-back accesses). Otherwise → IDLE.

General rules:
- `cpu_rdy` = state is IDLE or DONE. It is decoded from registered state.
- CPU holds its address, data and rw stable while `cpu_rdy`=0. The responder reads only latched copies.
- `cpu_valid` is ignored in REQ and WAIT.
- `mem_ack` outside REQ is ignored.
- `mem_addr` and `mem_wdata` are driven from the latches and stay valid for the whole of REQ.
- `cpu_din` holds its last value until the next completed read.

## Timing
- Reset values: state IDLE, `cpu_rdy`=1, `cpu_din`=$00, `mem_req`=0, `mem_we`=0, `mem_addr`=$0000, `mem_wdata`=$00, `bus_err`=0, wait counter 0.
- Reset asserted mid-access aborts immediately: `mem_req` drops asynchronously and no partial data is written to `cpu_din`.
- Minimum latency, with `cpu_valid` sampled at edge N:
  - `mem_req` is high in cycle N+1;
  - with `mem_ack` in cycle N+1, DONE and valid `cpu_din` in cycle N+2.
- An I/O access adds exactly IDLE→DONE latency + IO_WAIT cycles.
- A ROM write completes in DONE at cycle N+1.
- `mem_req` deasserts on the edge after `mem_ack`. There is never more than one outstanding request.

## Configuration
Macro `MOS6502S_RESP_TIMEOUT_EN`.

Defined:
- An 8-bit counter runs in REQ.
- When TIMEOUT cycles elapse without `mem_ack`:
  - `mem_req` drops;
  - a read returns `cpu_din`=$FF;
  - `bus_err` sets (sticky until reset);
  - the state goes to DONE.
- An ack on the same cycle as expiry wins: it is a normal completion and `bus_err` is not set.

Undefined:
- REQ waits indefinitely for the ack.
- `bus_err` is tied 0 and no counter logic exists.

## Structure
- Shared package `mos6502s_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, DONE);
  - the region enum (RAM, IO, ROM);
  - region base constants $8000 and $C000;
  - the timeout read value $FF.
- One sub-module, `mos6502s_region_decode`, is combinational: 16-bit address in, region out.
- The FSM, latches and counters stay in the top module.

## Test plan
- Reset release, then read of $1234 with `mem_ack` and `mem_rdata`=$5A one cycle after `mem_req` → `mem_addr`=$1234, `mem_we`=0, `cpu_din`=$5A with `cpu_rdy`=1 two cycles after `cpu_valid`.
- Write $A5 to $8010 with IO_WAIT=2 and an immediate ack → `mem_we`=1, `mem_wdata`=$A5, and `cpu_rdy` is low for 3 cycles total before DONE.
- Write to $F000 → `mem_req` never asserts, DONE on the next cycle, `cpu_din` unchanged.
- Back-to-back reads $0001 then $0002, with `cpu_valid` held in DONE → the second `mem_req` rises on the cycle after the first DONE, with no IDLE gap.
- With `MOS6502S_RESP_TIMEOUT_EN` and TIMEOUT=4, a read with no ack → after 4 REQ cycles `cpu_din`=$FF and `bus_err`=1, which stays 1 through later good accesses.
- `rst_n` pulled low during REQ → `mem_req`=0 and `cpu_rdy`=1 immediately. After release, a fresh read completes normally.
